fb_frame_ctrl: RTL
==================

Name: fb_frame_ctrl

Overview:
Single-clock controller that sequences the 640x480x12 frame-buffer BRAM. It captures one camera frame, or frames continuously, into the BRAM write port. It then streams the stored frame out of the BRAM read port to a downstream consumer (UART/processing) over a valid/ready interface. Capture and readout are mutually exclusive, so a frame is never overwritten while it is being read.

Parameters:
H_ACTIVE, 640, pixels per line
V_ACTIVE, 480, lines per frame
ADDR_W, 19, BRAM address width
PIX_W, 12, pixel width (RGB444)

Ports:
clk  in  1  controller/pixel clock; both BRAM ports are driven from this domain
rst_n  in  1  asynchronous active-low reset
cap_req  in  1  one-cycle pulse: capture next frame
cap_continuous  in  1  level: re-arm automatically after each frame
cam_vsync  in  1  high = vertical blanking; falling edge = frame start
cam_href  in  1  high = active line
cam_pixel_valid  in  1  qualifies cam_pixel
cam_pixel  in  PIX_W  camera pixel
bram_write_en  out  1  BRAM write enable
bram_cmos_pixel_valid  out  1  BRAM data qualifier; 1 whenever bram_write_en=1
bram_write_addr  out  ADDR_W  BRAM write address
bram_data_in  out  PIX_W  BRAM write data
rd_start  in  1  one-cycle pulse: stream stored frame
bram_read_en  out  1  BRAM read enable
bram_read_addr  out  ADDR_W  BRAM read address
bram_data_out  in  PIX_W  BRAM read data, valid 1 cycle after bram_read_en
rd_data  out  PIX_W  stream data
rd_valid  out  1  stream valid
rd_ready  in  1  stream ready
rd_last  out  1  marks final pixel (addr H_ACTIVE*V_ACTIVE-1)
frame_valid  out  1  BRAM holds a complete frame
frame_done  out  1  one-cycle pulse at end of capture
busy  out  1  state != IDLE
line_err  out  1  sticky: a line had a pixel count != H_ACTIVE; cleared on cap_req

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0; row/col counters, pending flags and skid buffer are cleared.
- States:
  - IDLE -> RD_RUN on rd_start (or pending rd) when frame_valid=1.
  - IDLE -> ARM on cap_req (or pending cap).
  - Same-cycle rd_start and cap_req in IDLE with frame_valid=1: readout wins; cap_req is latched as pending.
- ARM:
  - Entry clears frame_valid and line_err.
  - Wait for falling edge of cam_vsync, detected with a registered previous value -> CAPTURE, row=col=0.
- CAPTURE:
  - When cam_href & cam_pixel_valid & col<H_ACTIVE & row<V_ACTIVE:
    - bram_write_en=1, bram_write_addr=row*H_ACTIVE+col, bram_data_in=cam_pixel, col++.
  - Pixels with col>=H_ACTIVE are dropped.
  - On falling edge of href with col>0: if col!=H_ACTIVE set line_err; row++, col=0.
  - Address is recomputed from row/col, so short or long lines never shift later lines.
  - Exit on row==V_ACTIVE or rising edge of cam_vsync, whichever is first:
    - frame_done pulse; frame_valid=1 only if row==V_ACTIVE.
    - Next state: ARM if cap_continuous, or if cap pending and no rd pending; else IDLE.
- RD_RUN:
  - Addresses 0..H_ACTIVE*V_ACTIVE-1 are issued in order.
  - 2-entry skid buffer: bram_read_en asserted only when (buffered + in-flight) < 2.
  - Full throughput (1 pixel/cycle) while rd_ready=1.
  - rd_data/rd_valid hold stable while rd_valid & !rd_ready.
  - rd_last is asserted with the final pixel. When it is accepted -> IDLE, serving a pending cap first.
- Requests arriving in a non-IDLE state are latched (one deep each), never dropped.
  - rd_start with frame_valid=0 in IDLE is ignored.
- Arithmetic: row*H_ACTIVE uses ADDR_W-bit width. The read address wraps nowhere; it stops at the last pixel.

Optional Feature:
FB_TEST_PATTERN_EN
- Defined: during CAPTURE, bram_data_in = colour-bar pattern instead of cam_pixel. 8 vertical bars, bar index = col*8/H_ACTIVE, colours {FFF,FF0,0FF,0F0,F0F,F00,00F,000}. Camera timing still gates writes.
- Undefined: cam_pixel is written unchanged; no pattern logic is synthesised.

Decomposition:
- Package fb_pkg:
  - state enum {IDLE, ARM, CAPTURE, RD_RUN}
  - FB_PIXELS = H_ACTIVE*V_ACTIVE
  - colour-bar constant table
- One sub-module: fb_rd_skid (2-entry skid buffer turning 1-cycle-latency BRAM reads into valid/ready).

Test Plan:
- H_ACTIVE=4, V_ACTIVE=3; cap_req, then vsync fall, then 3 lines of 4 pixels 0x001..0x00C -> writes at addr 0..11 with those data; frame_done one pulse; frame_valid=1; line_err=0.
- Line 1 has 3 pixels, line 2 has 5 -> line_err=1; line 2 starts at addr 8; 5th pixel is not written.
- rd_start after capture, rd_ready toggling 1,0,0,1 -> rd_data sequence 0x001..0x00C with no loss or duplicate; rd_last only on 0x00C.
- cap_req during RD_RUN -> readout completes unaltered, then ARM; frame_valid drops on ARM entry.
- vsync rises after 2 lines -> frame_done pulses; frame_valid=0; rd_start ignored.
- rst_n low mid-CAPTURE at addr 5 -> all outputs 0 immediately; after release, state IDLE and frame_valid=0.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared state type, frame geometry defaults and colour-bar table
// for the frame-buffer controller.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        RD_RUN
    } fb_state_t;

    localparam int FB_H_ACTIVE = 640;
    localparam int FB_V_ACTIVE = 480;
    localparam int FB_ADDR_W   = 19;
    localparam int FB_PIX_W    = 12;
    localparam int FB_PIXELS   = FB_H_ACTIVE * FB_V_ACTIVE;

    // Bar 0 sits in the low 12 bits: FFF,FF0,0FF,0F0,F0F,F00,00F,000
    localparam logic [95:0] FB_BARS = {
        12'h000, 12'h00F, 12'hF00, 12'hF0F,
        12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
    };

    function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
        return FB_BARS[idx*12 +: 12];
    endfunction

endpackage

// File: rtl/fb_rd_skid.sv
// fb_rd_skid: 2-entry skid buffer turning 1-cycle-latency BRAM reads
// into a valid/ready stream; "space" throttles new reads.
module fb_rd_skid
    import fb_pkg::*;
#(
    parameter int PIX_W = FB_PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic             issue_last,
    input  logic [PIX_W-1:0] din,
    input  logic             rd_ready,
    output logic [PIX_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_last,
    output logic             space
);

    logic             inflight;
    logic             inflight_last;
    logic [1:0]       cnt;
    logic [PIX_W-1:0] buf0;
    logic [PIX_W-1:0] buf1;
    logic             last0;
    logic             last1;
    logic             push;
    logic             pop;
    logic [2:0]       occ;

    assign rd_valid = (cnt != 2'd0);
    assign rd_data  = buf0;
    assign rd_last  = last0 & rd_valid;
    assign push     = inflight;
    assign pop      = rd_valid & rd_ready;

    // Entries that will land in the buffer, net of this cycle's pop
    assign occ   = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
    assign space = (occ < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            cnt           <= 2'd0;
            buf0          <= '0;
            buf1          <= '0;
            last0         <= 1'b0;
            last1         <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue & issue_last;
            unique case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        buf0  <= din;
                        last0 <= inflight_last;
                    end else begin
                        buf1  <= din;
                        last1 <= inflight_last;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    buf0  <= buf1;
                    last0 <= last1;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        buf0  <= din;
                        last0 <= inflight_last;
                    end else begin
                        buf0  <= buf1;
                        last0 <= last1;
                        buf1  <= din;
                        last1 <= inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fb_frame_ctrl.sv
// fb_frame_ctrl: sequences camera capture into the frame BRAM and streams
// the stored frame out. Define FB_TEST_PATTERN_EN to write colour bars.
module fb_frame_ctrl
    import fb_pkg::*;
#(
    parameter int H_ACTIVE = FB_H_ACTIVE,
    parameter int V_ACTIVE = FB_V_ACTIVE,
    parameter int ADDR_W   = FB_ADDR_W,
    parameter int PIX_W    = FB_PIX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_req,
    input  logic              cap_continuous,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              cam_pixel_valid,
    input  logic [PIX_W-1:0]  cam_pixel,
    output logic              bram_write_en,
    output logic              bram_cmos_pixel_valid,
    output logic [ADDR_W-1:0] bram_write_addr,
    output logic [PIX_W-1:0]  bram_data_in,
    input  logic              rd_start,
    output logic              bram_read_en,
    output logic [ADDR_W-1:0] bram_read_addr,
    input  logic [PIX_W-1:0]  bram_data_out,
    output logic [PIX_W-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              frame_valid,
    output logic              frame_done,
    output logic              busy,
    output logic              line_err
);

    localparam logic [ADDR_W-1:0] H_W    = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] V_W    = ADDR_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    fb_state_t         state;
    logic              vsync_q;
    logic              href_q;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic              cap_pend;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_iss_done;
    logic              skid_space;
    logic              pix_wr;
    logic              href_fall;
    logic              vsync_fall;
    logic              vsync_rise;
    logic              rd_accept_last;
    logic [PIX_W-1:0]  pix_data;

`ifdef FB_TEST_PATTERN_EN
    logic [ADDR_W-1:0] bar_idx;
    assign bar_idx  = (col * ADDR_W'(8)) / H_W;
    assign pix_data = PIX_W'(bar_rgb(bar_idx[2:0]));
`else
    assign pix_data = cam_pixel;
`endif

    assign busy           = (state != IDLE);
    assign pix_wr         = cam_href & cam_pixel_valid & (col < H_W) & (row < V_W);
    assign href_fall      = href_q & ~cam_href;
    assign vsync_fall     = vsync_q & ~cam_vsync;
    assign vsync_rise     = ~vsync_q & cam_vsync;
    assign rd_accept_last = rd_valid & rd_ready & rd_last;
    assign bram_read_en   = (state == RD_RUN) & ~rd_iss_done & skid_space;
    assign bram_read_addr = rd_addr;

    fb_rd_skid #(
        .PIX_W(PIX_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (bram_read_en),
        .issue_last(rd_addr == LAST_A),
        .din       (bram_data_out),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .space     (skid_space)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            vsync_q               <= 1'b0;
            href_q                <= 1'b0;
            row                   <= '0;
            col                   <= '0;
            cap_pend              <= 1'b0;
            rd_pend               <= 1'b0;
            rd_addr               <= '0;
            rd_iss_done           <= 1'b0;
            bram_write_en         <= 1'b0;
            bram_cmos_pixel_valid <= 1'b0;
            bram_write_addr       <= '0;
            bram_data_in          <= '0;
            frame_valid           <= 1'b0;
            frame_done            <= 1'b0;
            line_err              <= 1'b0;
        end else begin
            vsync_q               <= cam_vsync;
            href_q                <= cam_href;
            bram_write_en         <= 1'b0;
            bram_cmos_pixel_valid <= 1'b0;
            frame_done            <= 1'b0;
            unique case (state)
                IDLE: begin
                    if ((rd_start | rd_pend) & frame_valid) begin
                        state       <= RD_RUN;
                        rd_pend     <= 1'b0;
                        cap_pend    <= cap_pend | cap_req;
                        rd_addr     <= '0;
                        rd_iss_done <= 1'b0;
                    end else begin
                        rd_pend <= 1'b0;
                        if (cap_req | cap_pend) begin
                            state    <= ARM;
                            cap_pend <= 1'b0;
                        end
                    end
                end
                ARM: begin
                    frame_valid <= 1'b0;
                    line_err    <= 1'b0;
                    cap_pend    <= cap_pend | cap_req;
                    rd_pend     <= rd_pend | rd_start;
                    if (vsync_fall) begin
                        state <= CAPTURE;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                CAPTURE: begin
                    cap_pend <= cap_pend | cap_req;
                    rd_pend  <= rd_pend | rd_start;
                    if ((row == V_W) | vsync_rise) begin
                        frame_done  <= 1'b1;
                        frame_valid <= (row == V_W);
                        if (cap_continuous |
                            ((cap_pend | cap_req) & ~(rd_pend | rd_start))) begin
                            state    <= ARM;
                            cap_pend <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (pix_wr) begin
                            bram_write_en         <= 1'b1;
                            bram_cmos_pixel_valid <= 1'b1;
                            // Address from row/col so a bad line never skews the next
                            bram_write_addr       <= row * H_W + col;
                            bram_data_in          <= pix_data;
                            col                   <= col + 1'b1;
                        end
                        if (href_fall & (col != '0)) begin
                            if (col != H_W) line_err <= 1'b1;
                            row <= row + 1'b1;
                            col <= '0;
                        end
                    end
                end
                RD_RUN: begin
                    cap_pend <= cap_pend | cap_req;
                    rd_pend  <= rd_pend | rd_start;
                    if (bram_read_en) begin
                        if (rd_addr == LAST_A) rd_iss_done <= 1'b1;
                        else                   rd_addr     <= rd_addr + 1'b1;
                    end
                    if (rd_accept_last) begin
                        if (cap_pend | cap_req) begin
                            state    <= ARM;
                            cap_pend <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
